out_stream_buffer: RTL and testbench

Output-side buffer that consumes the CPU's `out`/`outFlag` result stream and delivers it to an external byte-wide consumer (UART transmitter, display driver). Each word presented with `outFlag` high is queued in a small FIFO. A drain state machine then emits each word as two bytes, high byte first, over a valid/ready handshake. The CPU never stalls on this block: when the FIFO is full, incoming words are dropped and a sticky overflow flag is set.

---
 rtl/out_stream_pkg.sv | 4 +
 rtl/syncfifo.sv | 39 +++
 rtl/out_stream_buffer.sv | 59 +++++
 tb/tb_out_stream_buffer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/out_stream_pkg.sv
// out_stream_pkg: shared types for the output stream buffer
package out_stream_pkg;
    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} drain_state_t;
endpackage

// File: rtl/syncfifo.sv
// syncfifo: synchronous FIFO with wrapping pointers; push ignored when full, pop ignored when empty
module syncfifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic wrEn, rdEn;
    assign wrEn = push && !full;
    assign rdEn = pop && !empty;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rdPtr];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + 1'b1;
            if (rdEn) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(wrEn) - (AW+1)'(rdEn);
        end
    end
    always_ff @(posedge clock) begin
        if (wrEn) mem[wrPtr] <= din;
    end
endmodule

// File: rtl/out_stream_buffer.sv
// out_stream_buffer: queues CPU output words and drains them as high-then-low bytes over valid/ready
module out_stream_buffer
    import out_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     outFlag,
    input  logic [WIDTH-1:0]         out,
    output logic [WIDTH/2-1:0]       byteData,
    output logic                     byteValid,
    input  logic                     byteReady,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clearOverflow
);
    drain_state_t state, stateNext;
    logic [WIDTH-1:0] hold, headWord;
    logic pop, fire;
    syncfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo (
        .clock(clock),
        .reset(reset),
        .push(outFlag),
        .pop(pop),
        .din(out),
        .dout(headWord),
        .count(count),
        .full(full),
        .empty(empty)
    );
    assign fire = byteValid && byteReady;
    // Popping straight from SEND_LO keeps words back-to-back without an IDLE bubble
    always_comb begin
        pop = (state == IDLE || (state == SEND_LO && fire)) && !empty;
        stateNext = pop ? SEND_HI
                  : (state == SEND_HI && fire) ? SEND_LO
                  : (state == SEND_LO && fire) ? IDLE
                  : state;
        byteValid = state != IDLE;
        byteData = state == SEND_HI ? hold[WIDTH-1:WIDTH/2]
                 : state == SEND_LO ? hold[WIDTH/2-1:0]
                 : '0;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hold <= '0;
            overflow <= 1'b0;
        end else begin
            state <= stateNext;
            if (pop) hold <= headWord;
            overflow <= (outFlag && full) || (overflow && !clearOverflow);
        end
    end
endmodule

// File: tb/tb_out_stream_buffer.sv
// tb_out_stream_buffer: directed and random checks of out_stream_buffer against a queue-based model
module tb_out_stream_buffer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    logic clock, reset, outFlag, byteReady, clearOverflow;
    logic [WIDTH-1:0] out;
    logic [WIDTH/2-1:0] byteData;
    logic byteValid, full, empty, overflow;
    logic [$clog2(DEPTH):0] count;
    int checks = 0;
    int errors = 0;
    int peak = 0;
    logic [WIDTH-1:0] fq[$];
    int left = 0;
    logic [WIDTH-1:0] cur = '0;
    logic ovf = 1'b0;

    out_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .outFlag(outFlag),
        .out(out),
        .byteData(byteData),
        .byteValid(byteValid),
        .byteReady(byteReady),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .clearOverflow(clearOverflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [WIDTH/2-1:0] expData;
        expData = left == 2 ? cur[WIDTH-1:WIDTH/2] : left == 1 ? cur[WIDTH/2-1:0] : '0;
        chk({tag, ".count"}, 32'(count), 32'(fq.size()));
        chk({tag, ".full"}, 32'(full), 32'(fq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(fq.size() == 0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
        chk({tag, ".byteValid"}, 32'(byteValid), 32'(left > 0));
        chk({tag, ".byteData"}, 32'(byteData), 32'(expData));
        if (int'(count) > peak) peak = int'(count);
    endtask

    task automatic modelReset();
        fq.delete();
        left = 0;
        cur = '0;
        ovf = 1'b0;
    endtask

    // One clock: drive inputs, predict from pre-edge model state, check after the edge
    task automatic cyc(input string tag, input logic f, input logic [WIDTH-1:0] w, input logic r, input logic c);
        logic fire, wasFull, popNow;
        outFlag = f;
        out = w;
        byteReady = r;
        clearOverflow = c;
        fire = left > 0 && r;
        wasFull = fq.size() == DEPTH;
        popNow = (left == 0 || (fire && left == 1)) && fq.size() > 0;
        @(posedge clock);
        if (fire) left--;
        if (popNow) begin
            cur = fq.pop_front();
            left = 2;
        end
        if (f && !wasFull) fq.push_back(w);
        ovf = (f && wasFull) ? 1'b1 : c ? 1'b0 : ovf;
        #1 checkAll(tag);
    endtask

    initial begin
        reset = 1'b1;
        outFlag = 1'b0;
        out = '0;
        byteReady = 1'b0;
        clearOverflow = 1'b0;
        #12 checkAll("reset");
        @(negedge clock) reset = 1'b0;

        cyc("single.push", 1'b1, 16'hA55A, 1'b1, 1'b0);
        chk("single.latency", 32'(byteValid), 32'(0));
        cyc("single.hi", 1'b0, '0, 1'b1, 1'b0);
        chk("single.hiByte", 32'(byteData), 32'h A5);
        repeat (3) cyc("single.drain", 1'b0, '0, 1'b1, 1'b0);

        peak = 0;
        cyc("b2b.push", 1'b1, 16'h1234, 1'b1, 1'b0);
        cyc("b2b.push", 1'b1, 16'h5678, 1'b1, 1'b0);
        cyc("b2b.push", 1'b1, 16'h9ABC, 1'b1, 1'b0);
        repeat (7) cyc("b2b.drain", 1'b0, '0, 1'b1, 1'b0);
        chk("b2b.peak", 32'(peak), 32'(2));

        cyc("bp.push", 1'b1, 16'hBEEF, 1'b0, 1'b0);
        repeat (5) cyc("bp.hold", 1'b0, '0, 1'b0, 1'b0);
        chk("bp.heldByte", 32'(byteData), 32'h BE);
        repeat (3) cyc("bp.release", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 1; i <= 10; i++) cyc("ovf.push", 1'b1, 16'(i), 1'b0, 1'b0);
        chk("ovf.full", 32'(full), 32'(1));
        chk("ovf.flag", 32'(overflow), 32'(1));
        cyc("ovf.setWins", 1'b1, 16'h0077, 1'b0, 1'b1);
        chk("ovf.setWinsFlag", 32'(overflow), 32'(1));
        cyc("ovf.clear", 1'b0, '0, 1'b0, 1'b1);
        chk("ovf.cleared", 32'(overflow), 32'(0));
        repeat (22) cyc("ovf.drain", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) cyc("rst.fill", 1'b1, 16'h1100 + 16'(i), 1'b0, 1'b0);
        cyc("rst.toLo", 1'b0, '0, 1'b1, 1'b0);
        reset = 1'b1;
        modelReset();
        #1 checkAll("rst.async");
        @(negedge clock) reset = 1'b0;
        cyc("rst.push", 1'b1, 16'h00FF, 1'b1, 1'b0);
        repeat (4) cyc("rst.drain", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++)
            cyc("rand", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 15) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
